// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALUOp values, opcode/funct constants,
// multiplier FSM states and the EX/MEM payload.
package ex_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned MUL_CYC = 32;
  localparam int unsigned CNT_W   = $clog2(MUL_CYC);

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_SUB    = 2'b01,
    ALU_RTYPE  = 2'b10,
    ALU_IARITH = 2'b11
  } aluop_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_OR     = 3'b110;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] result;
    logic            zero;
    logic [2:0]      mem;
    logic [1:0]      wb;
  } exmem_t;

  // Loads, stores and immediate arithmetic carry a 12-bit immediate that must be sign-extended.
  function automatic logic [XLEN-1:0] fix_b(input logic [6:0] opcode, input logic [XLEN-1:0] rt);
    if (opcode == OP_LOAD || opcode == OP_STORE || opcode == OP_IARITH)
      return {{(XLEN-12){rt[11]}}, rt[11:0]};
    return rt;
  endfunction

endpackage

// File: rtl/ex_stage_unit_if.sv
// ID/EX input bundle and EX/MEM output bundle of the execute stage.
interface ex_stage_unit_if;
  import ex_pkg::*;

  logic [XLEN-1:0] inst_i;
  logic [XLEN-1:0] RSdata_i;
  logic [XLEN-1:0] RTdata_i;
  logic [1:0]      EX_signal_i;
  logic [2:0]      MEM_signal_i;
  logic [1:0]      WB_signal_i;
  logic            stall_o;
  logic [XLEN-1:0] inst_o;
  logic [XLEN-1:0] ALUresult_o;
  logic            zero_o;
  logic [2:0]      MEM_signal_o;
  logic [1:0]      WB_signal_o;

  modport master (
    output inst_i, RSdata_i, RTdata_i, EX_signal_i, MEM_signal_i, WB_signal_i,
    input  stall_o, inst_o, ALUresult_o, zero_o, MEM_signal_o, WB_signal_o
  );

  modport slave (
    input  inst_i, RSdata_i, RTdata_i, EX_signal_i, MEM_signal_i, WB_signal_i,
    output stall_o, inst_o, ALUresult_o, zero_o, MEM_signal_o, WB_signal_o
  );

endinterface

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier: one bit of B per cycle, low XLEN bits of the product.
module ex_mul_iter
  import ex_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] prod_o
);

  mul_state_e       state_q, state_d;
  logic [XLEN-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (b_q[cnt_q]) acc_d = acc_q + (a_q << cnt_q);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_CYC - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == BUSY);
  assign done_o = (state_q == DONE);
  assign prod_o = acc_q;

endmodule

// File: rtl/ex_stage_unit.sv
// Execute stage with EX/MEM register; single-cycle ALU, optional iterative MUL when
// EX_MUL_EN is defined (otherwise the MUL encoding yields 0 with no stall).
module ex_stage_unit
  import ex_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  ex_stage_unit_if.slave bus
);

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  aluop_e          aluop;
  logic [XLEN-1:0] op_a, op_b, alu_res, res_c;
  logic            stall_c;
  exmem_t          exmem_d, exmem_q;

  assign opcode = bus.inst_i[6:0];
  assign funct3 = bus.inst_i[14:12];
  assign funct7 = bus.inst_i[31:25];
  assign aluop  = aluop_e'(bus.EX_signal_i);
  assign op_a   = bus.RSdata_i;
  assign op_b   = fix_b(opcode, bus.RTdata_i);

  // Single-cycle ALU; unknown R-type combinations (and MUL) produce 0 here.
  always_comb begin
    alu_res = '0;
    case (aluop)
      ALU_ADD, ALU_IARITH: alu_res = op_a + op_b;
      ALU_SUB:             alu_res = op_a + ~op_b + XLEN'(1);
      ALU_RTYPE: begin
        if (funct3 == F3_AND)                                alu_res = op_a & op_b;
        else if (funct3 == F3_OR)                            alu_res = op_a | op_b;
        else if (funct3 == F3_ADDSUB && funct7 == F7_BASE)   alu_res = op_a + op_b;
        else if (funct3 == F3_ADDSUB && funct7 == F7_SUB)    alu_res = op_a + ~op_b + XLEN'(1);
      end
      default: alu_res = '0;
    endcase
  end

`ifdef EX_MUL_EN
  logic            is_mul, mul_busy, mul_done;
  logic [XLEN-1:0] mul_prod;

  assign is_mul = (aluop == ALU_RTYPE) && (funct3 == F3_ADDSUB) && (funct7 == F7_MUL);

  ex_mul_iter u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (is_mul),
    .a_i     (op_a),
    .b_i     (op_b),
    .busy_o  (mul_busy),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  // Stall covers the issuing IDLE cycle and every BUSY cycle; DONE lets ID/EX advance.
  assign stall_c = rst_i && (mul_busy || (is_mul && !mul_done));
  assign res_c   = mul_done ? mul_prod : alu_res;
`else
  assign stall_c = 1'b0;
  assign res_c   = alu_res;
`endif

  always_comb begin
    exmem_d = '{inst: bus.inst_i, result: res_c, zero: (res_c == '0),
                mem: bus.MEM_signal_i, wb: bus.WB_signal_i};
    if (stall_c) exmem_d = '{inst: '0, result: '0, zero: 1'b1, mem: '0, wb: '0};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) exmem_q <= '0;
    else        exmem_q <= exmem_d;
  end

  assign bus.stall_o      = stall_c;
  assign bus.inst_o       = exmem_q.inst;
  assign bus.ALUresult_o  = exmem_q.result;
  assign bus.zero_o       = exmem_q.zero;
  assign bus.MEM_signal_o = exmem_q.mem;
  assign bus.WB_signal_o  = exmem_q.wb;

endmodule

// File: tb/tb_ex_stage_unit.sv
// Scoreboard bench for ex_stage_unit: driver pushes reference results, monitor pops and
// compares on every EX/MEM load; tracks EX_MUL_EN to pick the expected MUL behaviour.
module tb_ex_stage_unit;
  import ex_pkg::*;

`ifdef EX_MUL_EN
  localparam int MUL_STALL = 33;
  localparam bit MUL_ON    = 1'b1;
`else
  localparam int MUL_STALL = 0;
  localparam bit MUL_ON    = 1'b0;
`endif

  typedef struct {
    logic [31:0] inst;
    logic [31:0] res;
    logic        zero;
    logic [2:0]  mem;
    logic [1:0]  wb;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  ex_stage_unit_if bus ();

  ex_stage_unit dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
    return {f7, 10'h2A5, f3, 5'd3, opc};
  endfunction

  function automatic bit ref_is_mul(input logic [31:0] inst, input logic [1:0] op);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = inst[31:25];
    f3 = inst[14:12];
    return (op == 2'd2) && (f3 == 3'd0) && (f7 == 7'd1);
  endfunction

  // Reference: signed immediate decoded as an integer, plain +,-,*,&,| on 32-bit values.
  function automatic logic [31:0] ref_result(input logic [31:0] inst, input logic [31:0] a,
                                             input logic [31:0] rt, input logic [1:0] op);
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] b;
    logic [11:0] imm12;
    int          imm;
    logic [63:0] prod;
    opc   = inst[6:0];
    f3    = inst[14:12];
    f7    = inst[31:25];
    imm12 = rt[11:0];
    if (opc == OP_LOAD || opc == OP_STORE || opc == OP_IARITH) begin
      imm = (int'(imm12) >= 2048) ? int'(imm12) - 4096 : int'(imm12);
      b   = 32'(imm);
    end else begin
      b = rt;
    end
    case (op)
      2'd0, 2'd3: return a + b;
      2'd1:       return a - b;
      default: begin
        if (f3 == 3'd7) return a & b;
        if (f3 == 3'd6) return a | b;
        if (f3 == 3'd0 && f7 == 7'h00) return a + b;
        if (f3 == 3'd0 && f7 == 7'h20) return a - b;
        if (f3 == 3'd0 && f7 == 7'h01) begin
          prod = 64'(a) * 64'(b);
          return MUL_ON ? prod[31:0] : 32'd0;
        end
        return 32'd0;
      end
    endcase
  endfunction

  // Called at a negedge; returns at a later negedge. abort_at>0 resets mid-stall.
  task automatic issue(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] rt,
                       input logic [1:0] op, input logic [2:0] mem, input logic [1:0] wb,
                       input int abort_at);
    int   stalls;
    exp_t e;
    bus.inst_i       = inst;
    bus.RSdata_i     = a;
    bus.RTdata_i     = rt;
    bus.EX_signal_i  = op;
    bus.MEM_signal_i = mem;
    bus.WB_signal_i  = wb;
    #1;
    stalls = 0;
    while (bus.stall_o === 1'b1 && stalls < 100) begin
      stalls++;
      if (abort_at > 0 && stalls == abort_at) begin
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      @(negedge clk);
      #1;
    end
    chk("stall_cycles", 32'(stalls), ref_is_mul(inst, op) ? 32'(MUL_STALL) : 32'd0);
    e.res  = ref_result(inst, a, rt, op);
    e.inst = inst;
    e.zero = (e.res == 32'd0);
    e.mem  = mem;
    e.wb   = wb;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: outputs after an edge are a reset image, a bubble, or the next scoreboard entry.
  initial begin
    logic prev_rst, prev_stall;
    bit   have_prev;
    exp_t e;
    have_prev = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (have_prev) begin
        if (!prev_rst) begin
          chk("reset_outputs", {bus.inst_o | bus.ALUresult_o},  32'd0);
          chk("reset_flags", {26'd0, bus.zero_o, bus.MEM_signal_o, bus.WB_signal_o}, 32'd0);
        end else if (!prev_stall) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output inst_o=%h with empty scoreboard", bus.inst_o);
          end else begin
            e = sb_q.pop_front();
            chk("inst_o", bus.inst_o, e.inst);
            chk("ALUresult_o", bus.ALUresult_o, e.res);
            chk("zero_o", 32'(bus.zero_o), 32'(e.zero));
            chk("MEM_signal_o", 32'(bus.MEM_signal_o), 32'(e.mem));
            chk("WB_signal_o", 32'(bus.WB_signal_o), 32'(e.wb));
          end
        end else begin
          chk("bubble_data", {bus.inst_o | bus.ALUresult_o}, 32'd0);
          chk("bubble_ctrl", {27'd0, bus.MEM_signal_o, bus.WB_signal_o}, 32'd0);
        end
      end
      if (!rst) chk("reset_stall", 32'(bus.stall_o), 32'd0);
      prev_rst   = rst;
      prev_stall = bus.stall_o;
      have_prev  = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  opcs [5];
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] a, rt;
    logic [1:0]  op;
    opcs = '{OP_LOAD, OP_STORE, OP_IARITH, OP_BRANCH, OP_RTYPE};
    bus.inst_i       = '0;
    bus.RSdata_i     = '0;
    bus.RTdata_i     = '0;
    bus.EX_signal_i  = '0;
    bus.MEM_signal_i = '0;
    bus.WB_signal_i  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    issue(mk(7'h00, 3'd0, OP_RTYPE), 32'd5, 32'd7, 2'd2, 3'b101, 2'b10, 0);
    issue(mk(7'h00, 3'd0, OP_IARITH), 32'd1, 32'h0000_0FFF, 2'd3, 3'b000, 2'b11, 0);
    issue(mk(7'h00, 3'd2, OP_STORE), 32'd1, 32'h0000_0FFF, 2'd0, 3'b010, 2'b00, 0);
    issue(mk(7'h00, 3'd0, OP_BRANCH), 32'h1234, 32'h1234, 2'd1, 3'b100, 2'b00, 0);
    issue(mk(7'h00, 3'd0, OP_BRANCH), 32'd3, 32'd2, 2'd1, 3'b100, 2'b00, 0);
    issue(mk(7'h20, 3'd0, OP_RTYPE), 32'd2, 32'd5, 2'd2, 3'b001, 2'b01, 0);
    do_reset();
    issue(mk(7'h00, 3'd7, OP_RTYPE), 32'hF0F0_1234, 32'h0FF0_FFFF, 2'd2, 3'b011, 2'b01, 0);
    issue(mk(7'h00, 3'd6, OP_RTYPE), 32'hF000_0000, 32'h0000_000F, 2'd2, 3'b011, 2'b01, 0);
    issue(mk(7'h01, 3'd0, OP_RTYPE), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, 3'b001, 2'b10, 0);
    issue(mk(7'h01, 3'd0, OP_RTYPE), 32'd6, 32'd7, 2'd2, 3'b001, 2'b10, 11);
    issue(mk(7'h01, 3'd0, OP_RTYPE), 32'd6, 32'd7, 2'd2, 3'b001, 2'b10, 0);

    for (int n = 0; n < 200; n++) begin
      opc = opcs[$urandom_range(0, 4)];
      op  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0, 1:    f3 = 3'd0;
        2:       f3 = 3'd7;
        3:       f3 = 3'd6;
        default: f3 = 3'($urandom);
      endcase
      a = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0:       rt = $urandom;
        1:       rt = a;
        default: rt = {20'd0, 12'($urandom)};
      endcase
      issue({f7, 10'($urandom), f3, 5'($urandom), opc}, a, rt, op,
            3'($urandom), 2'($urandom), 0);
      if (n == 100) do_reset();
    end

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
